// File: rtl/kpad_ctrl_if.sv
// Signal bundle between the keypad scanner, the sequencing controller and the display.
// The slave side is the controller; the master side drives the press reports.
interface kpad_ctrl_if;
    logic       key_en;
    logic [3:0] row_pressed;
    logic [3:0] col;
    logic       scan_tick;
    logic [3:0] digit_new;
    logic [3:0] digit_old;
    logic       key_valid;
    logic       busy;

    modport master (
        output key_en, row_pressed, col,
        input  scan_tick, digit_new, digit_old, key_valid, busy
    );

    modport slave (
        input  key_en, row_pressed, col,
        output scan_tick, digit_new, digit_old, key_valid, busy
    );
endinterface

// File: rtl/kpad_ctrl.sv
// Keypad sequencing controller: scan-tick divider, press/release debounce and
// hex decode with a two-digit history, one accepted digit per physical press.
module kpad_ctrl #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_TICKS = 20
) (
    input  logic       clk,
    input  logic       reset,
    kpad_ctrl_if.slave kp
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

    typedef enum logic [2:0] {
        IDLE,
        DEBOUNCE,
        ACCEPT,
        HOLD,
        RELEASE
    } state_t;

    state_t        state_reg, state_next;
    logic [DW-1:0] div_reg;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [3:0]    cap_row_reg, cap_row_next;
    logic [3:0]    cap_col_reg, cap_col_next;
    logic [3:0]    digit_new_reg, digit_new_next;
    logic [3:0]    digit_old_reg, digit_old_next;
    logic          tick;
    logic          held;

    function automatic logic one_hot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    // Captured buses are guaranteed one-hot, so a 2-bit index is an OR of bit pairs.
    function automatic logic [3:0] decode(input logic [3:0] row, input logic [3:0] c);
        logic [1:0] ri;
        logic [1:0] ci;
        logic [3:0] code;
        ri = {row[3] | row[2], row[3] | row[1]};
        ci = {c[3] | c[2], c[3] | c[1]};
        case ({ri, ci})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'hE;
            4'hD: code = 4'h0;
            4'hE: code = 4'hF;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    assign tick = (div_reg == DIV_LAST);
    assign held = ((kp.col & cap_col_reg) != 4'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_reg <= '0;
        end else if (tick) begin
            div_reg <= '0;
        end else begin
            div_reg <= div_reg + DW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            cap_row_reg   <= '0;
            cap_col_reg   <= '0;
            digit_new_reg <= '0;
            digit_old_reg <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            cap_row_reg   <= cap_row_next;
            cap_col_reg   <= cap_col_next;
            digit_new_reg <= digit_new_next;
            digit_old_reg <= digit_old_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        cap_row_next   = cap_row_reg;
        cap_col_next   = cap_col_reg;
        digit_new_next = digit_new_reg;
        digit_old_next = digit_old_reg;
        case (state_reg)
            IDLE: begin
                if (kp.key_en && one_hot(kp.row_pressed) && one_hot(kp.col)) begin
                    cap_row_next = kp.row_pressed;
                    cap_col_next = kp.col;
                    cnt_next     = '0;
                    state_next   = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                // A drop in held beats a coincident tick.
                if (!held) begin
                    state_next = IDLE;
                end else if (tick) begin
                    cnt_next = cnt_reg + CW'(1);
                    if (cnt_reg == CNT_LAST) begin
                        state_next     = ACCEPT;
                        digit_old_next = digit_new_reg;
                        digit_new_next = decode(cap_row_reg, cap_col_reg);
                    end
                end
            end
            ACCEPT: begin
                state_next = HOLD;
            end
            HOLD: begin
                if (!held) begin
                    cnt_next   = '0;
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                if (held) begin
                    state_next = HOLD;
                end else if (tick) begin
                    cnt_next = cnt_reg + CW'(1);
                    if (cnt_reg == CNT_LAST) begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign kp.scan_tick = tick;
    assign kp.digit_new = digit_new_reg;
    assign kp.digit_old = digit_old_reg;
    assign kp.key_valid = (state_reg == ACCEPT);
    assign kp.busy      = (state_reg != IDLE);
endmodule

// File: tb/tb_kpad_ctrl.sv
// Bench for kpad_ctrl: expected tick, strobe, busy window and digits are derived
// from press timing arithmetic (tick positions, hold length) and a decode table.
module tb_kpad_ctrl;
    localparam int SD = 4;
    localparam int DT = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   exp_valid = -1;
    int   bs = -1;
    int   be = -1;
    logic [3:0] m_new = 4'h0;
    logic [3:0] m_old = 4'h0;
    logic [3:0] pend = 4'h0;
    logic [3:0] code_tab [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                  4'h4, 4'h5, 4'h6, 4'hB,
                                  4'h7, 4'h8, 4'h9, 4'hC,
                                  4'hE, 4'h0, 4'hF, 4'hD};

    kpad_ctrl_if kp();

    kpad_ctrl #(.SCAN_DIV(SD), .DEBOUNCE_TICKS(DT)) dut (
        .clk   (clk),
        .reset (reset),
        .kp    (kp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, obs, expv);
        end
    endtask

    // Cycle k is the interval after the k-th rising edge following reset release.
    function automatic int first_tick(input int x);
        return x + (SD - 1 - (x % SD));
    endfunction

    function automatic int nth_tick(input int x);
        return first_tick(x) + SD * (DT - 1);
    endfunction

    function automatic logic [3:0] code_of(input logic [3:0] row, input logic [3:0] c);
        int r = 0;
        int k = 0;
        for (int i = 0; i < 4; i++) begin
            if (row[i]) r = i;
            if (c[i]) k = i;
        end
        return code_tab[r * 4 + k];
    endfunction

    task automatic step(input logic ken, input logic [3:0] row, input logic [3:0] colv);
        @(posedge clk);
        cyc++;
        #1;
        kp.key_en      = ken;
        kp.row_pressed = row;
        kp.col         = colv;
        @(negedge clk);
        if (cyc == exp_valid) begin
            m_old = m_new;
            m_new = pend;
        end
        chk("scan_tick", kp.scan_tick, (cyc % SD) == SD - 1);
        chk("key_valid", kp.key_valid, cyc == exp_valid);
        chk("busy", kp.busy, (cyc >= bs) && (cyc < be));
        chk("digit_new", kp.digit_new, m_new);
        chk("digit_old", kp.digit_old, m_old);
    endtask

    // Press: key_en in the next cycle, column held for h cycles, then released.
    // bounce adds a short release bounce plus a stray key_en while holding.
    // abort >= 0 stops driving that many cycles after key_en.
    task automatic press(input logic [3:0] row, input logic [3:0] colv, input int h,
                         input int gap, input bit bounce, input int abort);
        int t0, t3, d, d2, rs, last;
        bit ok, acc;
        logic [3:0] cv, rv;
        logic ke;
        t0  = cyc + 1;
        ok  = ($countones(row) == 1) && ($countones(colv) == 1);
        t3  = nth_tick(t0 + 1);
        d   = t0 + h;
        acc = ok && (d > t3);
        d2  = bounce ? d + 10 : d;
        exp_valid = -1;
        if (!ok) begin
            bs = -1;
            be = -1;
            last = d + gap;
        end else begin
            bs = t0 + 1;
            if (acc) begin
                exp_valid = t3 + 1;
                pend = code_of(row, colv);
                rs = ((d2 > t3 + 2) ? d2 : t3 + 2) + 1;
                be = nth_tick(rs) + 1;
            end else begin
                be = d + 1;
            end
            last = be + gap;
        end
        for (int c = t0; c < last; c++) begin
            if (abort >= 0 && c >= t0 + abort) break;
            cv = ((c < d) || (bounce && c >= d + 4 && c < d2)) ? colv : 4'b0000;
            ke = (c == t0) || (bounce && c == t3 + 3);
            rv = (c == t0) ? row : ((bounce && c == t3 + 3) ? 4'b0001 : 4'b0000);
            step(ke, rv, cv);
        end
        $display("press row=%b col=%b hold=%0d bounce=%0d accepted=%0d digits=%h/%h",
                 row, colv, h, bounce, acc, m_new, m_old);
    endtask

    initial begin
        logic [3:0] rr, cc;
        kp.key_en      = 1'b0;
        kp.row_pressed = 4'b0000;
        kp.col         = 4'b0000;
        repeat (3) begin
            @(negedge clk);
            chk("rst_scan_tick", kp.scan_tick, 4'h0);
            chk("rst_key_valid", kp.key_valid, 4'h0);
            chk("rst_busy", kp.busy, 4'h0);
            chk("rst_digit_new", kp.digit_new, 4'h0);
            chk("rst_digit_old", kp.digit_old, 4'h0);
        end
        reset = 1'b1;
        cyc = 0;
        repeat (12) step(1'b0, 4'b0000, 4'b0000);
        $display("reset released, idle ticks observed through cycle %0d", cyc);

        press(4'b0001, 4'b0010, 20, 4, 1'b0, -1);   // clean press -> 2
        press(4'b0010, 4'b0100, 4, 4, 1'b0, -1);    // glitch
        press(4'b1000, 4'b0001, 400, 4, 1'b0, -1);  // long hold -> E
        press(4'b0011, 4'b0010, 10, 4, 1'b0, -1);   // not one-hot row
        press(4'b0001, 4'b0100, 40, 4, 1'b1, -1);   // bounce + stray key_en -> 3

        for (int n = 0; n < 24; n++) begin
            rr = 4'(1 << $urandom_range(0, 3));
            cc = 4'(1 << $urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) rr = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 6) == 0) cc = 4'($urandom_range(0, 15));
            press(rr, cc, $urandom_range(1, 30), $urandom_range(1, 6), 1'b0, -1);
        end

        // Reset while in HOLD must clear everything without a clock edge.
        press(4'b0001, 4'b1000, 200, 4, 1'b0, 30);
        #2;
        reset = 1'b0;
        #1;
        chk("async_busy", kp.busy, 4'h0);
        chk("async_key_valid", kp.key_valid, 4'h0);
        chk("async_digit_new", kp.digit_new, 4'h0);
        chk("async_digit_old", kp.digit_old, 4'h0);
        kp.key_en      = 1'b0;
        kp.row_pressed = 4'b0000;
        kp.col         = 4'b0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        cyc = 0;
        m_new = 4'h0;
        m_old = 4'h0;
        exp_valid = -1;
        bs = -1;
        be = -1;
        $display("reset applied during hold");
        press(4'b0100, 4'b0100, 20, 4, 1'b0, -1);   // -> 9, old 0

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/kpad_ctrl.md
# kpad_ctrl

Keypad sequencing controller between the keypad scanner FSM and the display logic. Generates the scanner's scan-rate tick and debounces each reported press over a fixed number of scan ticks. Decodes the row/column pair to a hex digit and keeps a two-digit history (newest, previous). It also enforces one accepted digit per physical press, including release debounce.

## Interface

Parameters:
- `SCAN_DIV`, default 50000: clk cycles per scan tick. Must be ≥ 2.
- `DEBOUNCE_TICKS`, default 20: scan ticks that a press, or a release, must be stable. Must be ≥ 1.

Ports:
- `clk`, input, 1: system clock.
- `reset`, input, 1: asynchronous, active-low reset.
- `key_en`, input, 1: one-cycle press pulse from the scanner.
- `row_pressed`, input, 4: one-hot row reported with `key_en`. It is already time-aligned to `col`.
- `col`, input, 4: synchronized column lines, active-high.
- `scan_tick`, output, 1: one-cycle clock-enable that paces the scanner.
- `digit_new`, output, 4: most recently accepted key code.
- `digit_old`, output, 4: previously accepted key code.
- `key_valid`, output, 1: one-cycle strobe marking a newly accepted digit.
- `busy`, output, 1: high in any state other than IDLE.

## Operation

- **Reset.** All outputs are low or zero. The state is IDLE. The tick counter, debounce counter, `cap_row` and `cap_col` are zero.
- **Tick divider.** The counter runs 0..`SCAN_DIV`-1 and wraps. `scan_tick` = 1 while the count equals `SCAN_DIV`-1. The divider free-runs in every state.
- **`held`** = `(col & cap_col) != 0`.
- **Decode** (row bit i, col bit j → code):
  - row0: 1, 2, 3, A
  - row1: 4, 5, 6, B
  - row2: 7, 8, 9, C
  - row3: E, 0, F, D
- **IDLE**
  - Condition: `key_en`=1, `row_pressed` is one-hot and `col` is one-hot.
  - Action: capture `cap_row`/`cap_col`, clear the debounce counter, go to DEBOUNCE.
  - If either bus is not one-hot, ignore `key_en` and stay in IDLE.
- **DEBOUNCE**
  - On each `scan_tick` with `held`=1: increment the counter.
  - If `held`=0 on any cycle: go to IDLE. This is a glitch, and no digit is produced.
  - On a `scan_tick` with `held`=1 and count = `DEBOUNCE_TICKS`-1: go to ACCEPT. On the same edge, set `digit_old`←`digit_new` and `digit_new`←decode(`cap_row`, `cap_col`).
- **ACCEPT**
  - Lasts one cycle, with `key_valid`=1. Then go to HOLD.
- **HOLD**
  - Stay while `held`=1.
  - When `held`=0: clear the counter and go to RELEASE.
- **RELEASE**
  - On each `scan_tick` with `held`=0: increment the counter.
  - If `held`=1: go back to HOLD. This is release bounce, and no new digit is produced.
  - On a `scan_tick` with `held`=0 and count = `DEBOUNCE_TICKS`-1: go to IDLE.
- **`key_en` outside IDLE** is ignored. Second keys pressed during HOLD are never reported.
- **Counter width** is ⌈log2(`DEBOUNCE_TICKS`+1)⌉. The counter never wraps, because it is cleared on every entry to DEBOUNCE or RELEASE.

## Timing

- `scan_tick` first asserts at cycle `SCAN_DIV`-1 after reset deassertion. After that it asserts every `SCAN_DIV` cycles.
- **Accept latency.** From `key_en` to `key_valid` is `DEBOUNCE_TICKS` scan ticks, plus 1 cycle.
- **Digit timing.** `digit_new` and `digit_old` already hold the new values in the cycle where `key_valid`=1. They are stable until the next accept.
- **`key_en` and `scan_tick` in the same cycle in IDLE.** The tick does not count. Counting starts with the next tick.
- **`held` drop and `scan_tick` in the same cycle.** The drop wins: DEBOUNCE goes to IDLE, and RELEASE counts.
- **Reset mid-operation.** Any state returns to IDLE immediately (asynchronously). Digits are cleared and `key_valid` drops in the same instant.
- All outputs are registered or decoded from state. There is no combinational path from `col` to `key_valid`.

## Test plan

All scenarios use `SCAN_DIV`=4 and `DEBOUNCE_TICKS`=3.

1. **Reset.** Assert reset for 3 cycles, then release. Required: all outputs are 0 and `busy`=0. `scan_tick` pulses on cycles 3, 7 and 11 after release.
2. **Clean press.** `key_en` with row=0001 and col=0010, col held for 20 cycles. Required: exactly one `key_valid`, 3 ticks plus 1 cycle after `key_en`, with `digit_new`=2 and `digit_old`=0.
3. **Glitch.** `key_en` with row=0010 and col=0100; col returns to 0000 after 1 tick. Required: no `key_valid`, the digits are unchanged, and the FSM is back in IDLE on the next cycle.
4. **Second key and long hold.** After scenario 2 and a clean release, `key_en` with row=1000 and col=0001, held for 100 ticks. Required: one `key_valid` only, with `digit_new`=E and `digit_old`=2.
5. **Ignored inputs.**
   - `key_en` with row=0011 → nothing happens and the FSM stays in IDLE.
   - `key_en` during HOLD, and a release bounce of 1 tick, → the FSM returns to HOLD with no extra `key_valid`.
6. **Reset during HOLD.** Required: `busy` drops and both digits read 0 without waiting for a clock. The next press (row=0100, col=0100) produces `digit_new`=9 and `digit_old`=0.
